// File: rtl/uart_test_tx.sv
// uart_test_tx: 8-bit UART transmitter with a small byte FIFO, LSB first, 1 start / 8 data / [parity] / 1 stop.
// Latency: a byte written into an empty FIFO while idle is popped on the next clock; start bit is driven from that edge.
// Backpressure: o_Tx_Ready drops when the FIFO holds FIFO_DEPTH bytes; writes while not ready are dropped silently.
//
// Ports:
//   i_Clock     system clock, rising edge
//   i_Rst_n     asynchronous active-low reset
//   i_Tx_DV     write strobe, accepted when o_Tx_Ready=1
//   i_Tx_Byte   byte to queue
//   o_Tx_Ready  FIFO not full (registered)
//   o_Tx_Active high whenever the FSM is not IDLE
//   o_Tx_Serial serial line, idles high (registered)
//   o_Tx_Done   one-clock pulse after each stop bit
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit after data bit 7
// (even parity, or odd when PARITY_ODD=1). Without it the frame is 8N1.

module uart_test_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);

  // Illegal configurations stop elaboration rather than building a broken transmitter.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_test_tx: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
`endif

  state_t        state;
  logic [15:0]   clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_shift;

  // Byte FIFO: power-of-two depth, so pointers wrap naturally.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          wr_en;
  logic          pop;

  // Ready reflects the count before this edge, so a full FIFO never
  // admits a write even if the FSM pops on the same edge.
  assign wr_en = i_Tx_DV & o_Tx_Ready;
  assign pop   = (state == IDLE) && (count != '0);

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)
      count_nxt = count + 1'b1;
    else if (!wr_en && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en)
      fifo_mem[wr_ptr] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Tx_Ready <= 1'b1;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      o_Tx_Ready <= (count_nxt < DEPTH_C);
    end
  end

  assign o_Tx_Active = (state != IDLE);

  // Serial FSM. o_Tx_Serial is set on the edge that enters each bit so the
  // line is registered and every bit lasts exactly CLKS_PER_BIT clocks.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      tx_shift    <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          if (pop) begin
            tx_shift    <= fifo_mem[rd_ptr];
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= 1'b0;
            state       <= START;
          end
        end

        START: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= tx_shift[0];
            state       <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              o_Tx_Serial <= (PARITY_ODD != 0) ? ~^tx_shift : ^tx_shift;
              state       <= PARITY;
`else
              o_Tx_Serial <= 1'b1;
              state       <= STOP;
`endif
            end else begin
              bit_idx     <= bit_idx + 1'b1;
              o_Tx_Serial <= tx_shift[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= 1'b1;
            state       <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Done   <= 1'b1;
            state       <= CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          o_Tx_Serial <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_test_tx.sv
// Bench for uart_test_tx: each scenario drives the DUT, captures its outputs once per clock
// and compares them with waveforms predicted from the frame timing rules, plus directed constants.
// The line is also decoded back into bytes to confirm what was actually transmitted.

module tb_uart_test_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * CPB;

  logic       i_Clock;
  logic       i_Rst_n;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;

  uart_test_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .PARITY_ODD  (PODD)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Tx_DV    (i_Tx_DV),
    .i_Tx_Byte  (i_Tx_Byte),
    .o_Tx_Ready (o_Tx_Ready),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done  (o_Tx_Done)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int checks   = 0;
  int failures = 0;

  logic       stim_vld[$];
  logic [7:0] stim_dat[$];
  logic       cap_ser[$], cap_done[$], cap_act[$], cap_rdy[$];
  logic       exp_ser[$], exp_done[$], exp_act[$], exp_rdy[$];
  int         acc_edge[$];
  int         pop_edge[$];
  logic [7:0] pop_byte[$];

  // Line level of frame bit k (start, d0..d7, [parity], stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return (PODD != 0) ? ~^b : ^b;
`endif
    return 1'b1;
  endfunction

  // Runs n clocks from a negedge with an empty, idle DUT. Sample i reflects the state after
  // posedge i-1; a write driven at negedge i lands on posedge i. Expected behaviour: a byte
  // accepted at edge e is popped at max(e+1, previous pop + FR + 2); its frame occupies edges
  // pop..pop+FR-1, Done follows on edge pop+FR, and the FIFO holds bytes accepted but not yet popped.
  task automatic run(input int n);
    int t, inq, p, last_pop;
    logic es, ed, ea, er, v;
    logic [7:0] d;
    cap_ser.delete(); cap_done.delete(); cap_act.delete(); cap_rdy.delete();
    exp_ser.delete(); exp_done.delete(); exp_act.delete(); exp_rdy.delete();
    acc_edge.delete(); pop_edge.delete(); pop_byte.delete();
    last_pop = -1000;
    for (int i = 0; i < n; i++) begin
      t = i - 1;
      inq = 0;
      es = 1'b1; ed = 1'b0; ea = 1'b0;
      foreach (pop_edge[k]) begin
        p = pop_edge[k];
        if (acc_edge[k] <= t && p > t) inq++;
        if (t >= p && t < p + FR) es = frame_bit(pop_byte[k], (t - p) / CPB);
        if (t == p + FR) ed = 1'b1;
        if (t >= p && t <= p + FR) ea = 1'b1;
      end
      er = (inq < DEPTH);
      cap_ser.push_back(o_Tx_Serial); cap_done.push_back(o_Tx_Done);
      cap_act.push_back(o_Tx_Active); cap_rdy.push_back(o_Tx_Ready);
      exp_ser.push_back(es); exp_done.push_back(ed); exp_act.push_back(ea); exp_rdy.push_back(er);
      v = (i < stim_vld.size()) ? stim_vld[i] : 1'b0;
      d = (i < stim_dat.size()) ? stim_dat[i] : 8'h00;
      i_Tx_DV = v;
      i_Tx_Byte = d;
      if (v && er) begin
        p = (i + 1 > last_pop + FR + 2) ? i + 1 : last_pop + FR + 2;
        acc_edge.push_back(i); pop_edge.push_back(p); pop_byte.push_back(d);
        last_pop = p;
      end
      @(negedge i_Clock);
    end
    i_Tx_DV = 1'b0;
    stim_vld.delete(); stim_dat.delete();
  endtask

  // Recovers transmitted bytes from the captured line by sampling mid-bit after each start edge.
  task automatic decode_line(output logic [7:0] q[$]);
    int i;
    logic [7:0] b;
    q.delete();
    i = 1;
    while (i + FR <= cap_ser.size()) begin
      if (cap_ser[i-1] === 1'b1 && cap_ser[i] === 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = cap_ser[i + (j + 1) * CPB + CPB / 2];
        q.push_back(b);
        i += FR;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    i_Rst_n = 1'b0; i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00;
    repeat (3) @(negedge i_Clock);
    checks++; if (o_Tx_Serial !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b want=1", o_Tx_Serial); end
    checks++; if (o_Tx_Active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", o_Tx_Active); end
    checks++; if (o_Tx_Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_Tx_Done); end
    checks++; if (o_Tx_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_Tx_Ready); end
    i_Rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge i_Clock);
      if (o_Tx_Serial !== 1'b1 || o_Tx_Done !== 1'b0 || o_Tx_Active !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_idle_line bad_clocks=%0d want=0", bad); end
  endtask

  task automatic test_single_byte();
    int ms, md, ma, mr, nd;
    logic [7:0] dec[$];
    stim_vld = '{1'b1};
    stim_dat = '{8'hA5};
    run(50);
    ms = 0; md = 0; ma = 0; mr = 0; nd = 0;
    foreach (cap_ser[i]) begin
      if (cap_ser[i] !== exp_ser[i]) ms++;
      if (cap_done[i] !== exp_done[i]) md++;
      if (cap_act[i] !== exp_act[i]) ma++;
      if (cap_rdy[i] !== exp_rdy[i]) mr++;
      if (cap_done[i] === 1'b1) nd++;
    end
    checks++; if (ms != 0) begin failures++; $display("FAIL single_serial differing_samples=%0d want=0", ms); end
    checks++; if (md != 0) begin failures++; $display("FAIL single_done differing_samples=%0d want=0", md); end
    checks++; if (ma != 0) begin failures++; $display("FAIL single_active differing_samples=%0d want=0", ma); end
    checks++; if (mr != 0) begin failures++; $display("FAIL single_ready differing_samples=%0d want=0", mr); end
    checks++; if (cap_ser[1] !== 1'b1 || cap_ser[2] !== 1'b0) begin
      failures++; $display("FAIL single_start_latency got=%b%b want=10", cap_ser[1], cap_ser[2]); end
    checks++; if (nd != 1 || cap_done[42] !== 1'b1) begin
      failures++; $display("FAIL single_done_pulse count=%0d at42=%b want count=1 at42=1", nd, cap_done[42]); end
    decode_line(dec);
    checks++; if (dec.size() != 1 || dec[0] !== 8'hA5) begin
      failures++; $display("FAIL single_decode frames=%0d want 1 frame of a5", dec.size()); end
  endtask

  task automatic test_fifo_full();
    int ms, md, ma, mr, nd;
    logic ok;
    logic [7:0] dec[$];
    for (int i = 0; i < 6; i++) begin
      stim_vld.push_back(1'b1);
      stim_dat.push_back(8'h10 + 8'(i));
    end
    run(240);
    ms = 0; md = 0; ma = 0; mr = 0; nd = 0;
    foreach (cap_ser[i]) begin
      if (cap_ser[i] !== exp_ser[i]) ms++;
      if (cap_done[i] !== exp_done[i]) md++;
      if (cap_act[i] !== exp_act[i]) ma++;
      if (cap_rdy[i] !== exp_rdy[i]) mr++;
      if (cap_done[i] === 1'b1) nd++;
    end
    checks++; if (ms != 0) begin failures++; $display("FAIL fifo_serial differing_samples=%0d want=0", ms); end
    checks++; if (md != 0) begin failures++; $display("FAIL fifo_done differing_samples=%0d want=0", md); end
    checks++; if (ma != 0) begin failures++; $display("FAIL fifo_active differing_samples=%0d want=0", ma); end
    checks++; if (mr != 0) begin failures++; $display("FAIL fifo_ready differing_samples=%0d want=0", mr); end
    checks++; if (cap_rdy[4] !== 1'b1 || cap_rdy[5] !== 1'b0) begin
      failures++; $display("FAIL fifo_ready_drop got=%b%b want=10", cap_rdy[4], cap_rdy[5]); end
    checks++; if (nd != 5) begin failures++; $display("FAIL fifo_done_count got=%0d want=5", nd); end
    decode_line(dec);
    ok = (dec.size() == 5);
    foreach (dec[k]) if (ok && dec[k] !== 8'h10 + 8'(k)) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL fifo_decode frames=%0d want 10..14", dec.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int ms, md, ma, mr, nd;
    for (int i = 0; i < 3; i++) begin
      stim_vld.push_back(1'b1);
      stim_dat.push_back(8'h00);
    end
    run(20);
    ms = 0;
    foreach (cap_ser[i]) if (cap_ser[i] !== exp_ser[i]) ms++;
    checks++; if (ms != 0) begin failures++; $display("FAIL midrst_pre_serial differing_samples=%0d want=0", ms); end
    checks++; if (o_Tx_Serial !== 1'b0) begin failures++; $display("FAIL midrst_in_bit3 got=%b want=0", o_Tx_Serial); end
    #2 i_Rst_n = 1'b0;
    #1;
    checks++; if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0 || o_Tx_Ready !== 1'b1) begin
      failures++; $display("FAIL midrst_async ser=%b act=%b rdy=%b want 1 0 1", o_Tx_Serial, o_Tx_Active, o_Tx_Ready); end
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    run(60);
    ms = 0; md = 0; ma = 0; mr = 0; nd = 0;
    foreach (cap_ser[i]) begin
      if (cap_ser[i] !== exp_ser[i]) ms++;
      if (cap_done[i] !== exp_done[i]) md++;
      if (cap_act[i] !== exp_act[i]) ma++;
      if (cap_rdy[i] !== exp_rdy[i]) mr++;
      if (cap_done[i] === 1'b1) nd++;
    end
    checks++; if (ms != 0) begin failures++; $display("FAIL midrst_post_serial differing_samples=%0d want=0", ms); end
    checks++; if (ma != 0 || mr != 0) begin failures++; $display("FAIL midrst_post_state act_diff=%0d rdy_diff=%0d want 0", ma, mr); end
    checks++; if (md != 0 || nd != 0) begin failures++; $display("FAIL midrst_post_done pulses=%0d want=0", nd); end
  endtask

  task automatic test_random_traffic();
    int ms, md, ma, mr;
    logic ok;
    logic [7:0] dec[$];
    for (int i = 0; i < 300; i++) begin
      stim_vld.push_back($urandom_range(0, 3) == 0);
      stim_dat.push_back(8'($urandom));
    end
    run(600);
    ms = 0; md = 0; ma = 0; mr = 0;
    foreach (cap_ser[i]) begin
      if (cap_ser[i] !== exp_ser[i]) ms++;
      if (cap_done[i] !== exp_done[i]) md++;
      if (cap_act[i] !== exp_act[i]) ma++;
      if (cap_rdy[i] !== exp_rdy[i]) mr++;
    end
    checks++; if (ms != 0) begin failures++; $display("FAIL rand_serial differing_samples=%0d want=0", ms); end
    checks++; if (md != 0) begin failures++; $display("FAIL rand_done differing_samples=%0d want=0", md); end
    checks++; if (ma != 0) begin failures++; $display("FAIL rand_active differing_samples=%0d want=0", ma); end
    checks++; if (mr != 0) begin failures++; $display("FAIL rand_ready differing_samples=%0d want=0", mr); end
    decode_line(dec);
    ok = (dec.size() == pop_byte.size());
    foreach (dec[k]) if (ok && dec[k] !== pop_byte[k]) ok = 1'b0;
    checks++; if (!ok) begin
      failures++; $display("FAIL rand_decode frames=%0d want=%0d", dec.size(), pop_byte.size()); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int ms;
    stim_vld = '{1'b1};
    stim_dat = '{8'h07};
    run(50);
    ms = 0;
    foreach (cap_ser[i]) if (cap_ser[i] !== exp_ser[i]) ms++;
    checks++; if (ms != 0) begin failures++; $display("FAIL parity_serial differing_samples=%0d want=0", ms); end
    checks++; if (cap_ser[38] !== ((PODD != 0) ? 1'b0 : 1'b1)) begin
      failures++; $display("FAIL parity_bit got=%b want=%b", cap_ser[38], (PODD != 0) ? 1'b0 : 1'b1); end
    checks++; if (cap_ser[42] !== 1'b1 || cap_done[46] !== 1'b1) begin
      failures++; $display("FAIL parity_frame_len stop=%b done46=%b want 1 1", cap_ser[42], cap_done[46]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_fifo_full();
    test_reset_mid_frame();
    test_random_traffic();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
